cdb_slot_scheduler: RTL and testbench

- Issue-time reservation scheduler for the common data bus (CDB) writeback slot.
- Each fixed-latency functional unit (FU) requests a CDB slot when it issues. The block grants the request only if the slot L cycles ahead is free, so the FUs never collide on the CDB.
- Drives the one-hot `fu_sel` that steers the CDB result mux. Sits between the issue stage and the CDB.

---
 rtl/cdb_slot_scheduler.sv | 165 ++++++++++++++++
 tb/tb_cdb_slot_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cdb_slot_scheduler.sv
// Issue-time CDB writeback slot reservation scheduler for fixed-latency FUs.
// Optional macro CDB_DENY_CNT_EN enables the saturating denied-request counter.
module cdb_slot_scheduler #(
    parameter int                  NUM_FU  = 3,
    parameter int                  MAX_LAT = 8,
    parameter logic [4*NUM_FU-1:0] LAT_VEC = {4'd3, 4'd3, 4'd1}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [NUM_FU-1:0] iss_req,
    output logic [NUM_FU-1:0] iss_gnt,
    output logic [NUM_FU-1:0] fu_sel,
    output logic              cdb_valid,
    output logic [15:0]       deny_cnt
);

    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Each slot stores its owner one-hot; an all-zero entry is an invalid slot.
    logic [NUM_FU-1:0] slot_q [MAX_LAT];
    logic [NUM_FU-1:0] slot_d [MAX_LAT];
    logic [3:0]        lat_s  [NUM_FU];
    logic [NUM_FU-1:0] free_s;
    logic [NUM_FU-1:0] gnt_s;
    logic [15:0]       taken_s;
    logic              hit_s;
    logic              found_s;
    logic              run_s;
    logic [PW-1:0]     rr_q;
    logic [PW-1:0]     rr_d;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        localparam int LI = int'(LAT_VEC[4*i +: 4]);
        if ((LI < 1) || (LI > MAX_LAT)) begin : g_lat_bad
            $error("cdb_slot_scheduler: FU latency out of range 1..MAX_LAT");
        end
        assign lat_s[i] = LAT_VEC[4*i +: 4];
    end

    assign run_s     = rst & ~stall_i & ~flush_i;
    assign iss_gnt   = gnt_s;
    assign fu_sel    = slot_q[0];
    assign cdb_valid = |slot_q[0];

    // Target-slot availability in the pre-shift table; slot[MAX_LAT] is always free.
    always_comb begin
        free_s = '1;
        for (int i = 0; i < NUM_FU; i++) begin
            for (int k = 1; k < MAX_LAT; k++) begin
                if ((int'(lat_s[i]) == k) && (|slot_q[k])) begin
                    free_s[i] = 1'b0;
                end else begin
                    free_s[i] = free_s[i];
                end
            end
        end
    end

    // Round-robin grant: walk FUs in priority order, one winner per latency group.
    always_comb begin
        gnt_s   = '0;
        taken_s = 16'h0000;
        hit_s   = 1'b0;
        found_s = 1'b0;
        rr_d    = rr_q;
        if (run_s) begin
            for (int o = 0; o < NUM_FU; o++) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    hit_s = (i == ((int'(rr_q) + o) % NUM_FU)) & iss_req[i]
                            & free_s[i] & ~taken_s[lat_s[i]];
                    gnt_s[i]          = gnt_s[i] | hit_s;
                    taken_s[lat_s[i]] = taken_s[lat_s[i]] | hit_s;
                    if (hit_s && !found_s) begin
                        found_s = 1'b1;
                        rr_d    = PW'((i + 1) % NUM_FU);
                    end else begin
                        found_s = found_s;
                    end
                end
            end
        end else begin
            gnt_s = '0;
        end
    end

    // Next table: flush clears, stall holds, otherwise shift and insert grants.
    always_comb begin
        slot_d = slot_q;
        if (flush_i) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                slot_d[k] = '0;
            end
        end else if (!stall_i) begin
            for (int k = 0; k < MAX_LAT - 1; k++) begin
                slot_d[k] = slot_q[k+1];
            end
            slot_d[MAX_LAT-1] = '0;
            for (int k = 0; k < MAX_LAT; k++) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (gnt_s[i] && (int'(lat_s[i]) == (k + 1))) begin
                        slot_d[k][i] = 1'b1;
                    end else begin
                        slot_d[k][i] = slot_d[k][i];
                    end
                end
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // Reservation table and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                slot_q[k] <= '0;
            end
            rr_q <= '0;
        end else begin
            slot_q <= slot_d;
            rr_q   <= rr_d;
        end
    end

`ifdef CDB_DENY_CNT_EN
    logic [15:0] deny_q;
    logic [15:0] deny_d;
    logic [16:0] dsum_s;

    function automatic logic [15:0] popcnt(input logic [NUM_FU-1:0] v);
        logic [15:0] c;
        c = 16'd0;
        for (int j = 0; j < NUM_FU; j++) begin
            c = c + {15'd0, v[j]};
        end
        return c;
    endfunction

    // Saturating accumulation of denied requests in non-stalled, non-flushed cycles.
    always_comb begin
        dsum_s = {1'b0, deny_q} + {1'b0, popcnt(iss_req & ~gnt_s)};
        if (run_s) begin
            deny_d = dsum_s[16] ? 16'hFFFF : dsum_s[15:0];
        end else begin
            deny_d = deny_q;
        end
    end

    // Deny counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deny_q <= 16'h0000;
        end else begin
            deny_q <= deny_d;
        end
    end

    assign deny_cnt = deny_q;
`else
    assign deny_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed-vector bench for cdb_slot_scheduler (LAT: FU0=1, FU1=3, FU2=3).
module tb_cdb_slot_scheduler;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  iss_req = 3'b000;
    logic [2:0]  iss_gnt;
    logic [2:0]  fu_sel;
    logic        cdb_valid;
    logic [15:0] deny_cnt;

    int n_cmp  = 0;
    int n_err  = 0;
    int row_no = 0;

    always #5 clk = ~clk;

    cdb_slot_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .iss_req   (iss_req),
        .iss_gnt   (iss_gnt),
        .fu_sel    (fu_sel),
        .cdb_valid (cdb_valid),
        .deny_cnt  (deny_cnt)
    );

    task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %0h, want %0h", tag, row_no, obs, exp);
        end
    endtask

    function automatic logic [15:0] dn(input logic [15:0] v);
`ifdef CDB_DENY_CNT_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    // One cycle: drive inputs just after the edge, check mid-cycle.
    task automatic row(input logic [2:0] req, input logic stl, input logic fl,
                       input logic [2:0] gnt, input logic [2:0] sel, input logic [15:0] den);
        @(posedge clk);
        #1;
        iss_req = req;
        stall_i = stl;
        flush_i = fl;
        #4;
        row_no++;
        chk_val("iss_gnt",   {13'd0, iss_gnt},   {13'd0, gnt});
        chk_val("fu_sel",    {13'd0, fu_sel},    {13'd0, sel});
        chk_val("cdb_valid", {15'd0, cdb_valid}, {15'd0, |sel});
        chk_val("deny_cnt",  deny_cnt,           dn(den));
    endtask

    always @(negedge clk) begin
        chk_val("onehot0", {15'd0, $onehot0(fu_sel)}, 16'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        rst     = 1'b0;
        iss_req = 3'b111;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #5;
            chk_val("rst_gnt",   {13'd0, iss_gnt},   16'd0);
            chk_val("rst_sel",   {13'd0, fu_sel},    16'd0);
            chk_val("rst_valid", {15'd0, cdb_valid}, 16'd0);
            chk_val("rst_deny",  deny_cnt,           16'd0);
        end
        rst     = 1'b1;
        iss_req = 3'b000;

        for (int c = 0; c < 10; c++) row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd0);

        // single issue, L=1
        row(3'b001, 1'b0, 1'b0, 3'b001, 3'b000, 16'd0);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b001, 16'd0);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd0);
        // collision: FU1 holds bus cycle, later FU0 denied
        row(3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 16'd0);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd0);
        row(3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 16'd0);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b010, 16'd1);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd1);
        // FU2 alone brings rr_ptr back to 0
        row(3'b100, 1'b0, 1'b0, 3'b100, 3'b000, 16'd1);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd1);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd1);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 16'd1);
        // round-robin between same-latency FU1/FU2
        row(3'b110, 1'b0, 1'b0, 3'b010, 3'b000, 16'd1);
        row(3'b110, 1'b0, 1'b0, 3'b100, 3'b000, 16'd2);
        row(3'b110, 1'b0, 1'b0, 3'b010, 3'b000, 16'd3);
        row(3'b110, 1'b0, 1'b0, 3'b100, 3'b010, 16'd4);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 16'd5);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b010, 16'd5);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 16'd5);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd5);
        // distinct latencies granted together, FU2 loses to FU1
        row(3'b111, 1'b0, 1'b0, 3'b011, 3'b000, 16'd5);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b001, 16'd6);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd6);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b010, 16'd6);
        // rr_ptr=1: FU2 first in order, pointer wraps to 0
        row(3'b101, 1'b0, 1'b0, 3'b101, 3'b000, 16'd6);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b001, 16'd6);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd6);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 16'd6);
        // stall delays the FU1 broadcast by two cycles
        row(3'b110, 1'b0, 1'b0, 3'b010, 3'b000, 16'd6);
        row(3'b001, 1'b1, 1'b0, 3'b000, 3'b000, 16'd7);
        row(3'b110, 1'b1, 1'b0, 3'b000, 3'b000, 16'd7);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd7);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd7);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b010, 16'd7);
        // stall holds a live owner on the bus
        row(3'b001, 1'b0, 1'b0, 3'b001, 3'b000, 16'd7);
        row(3'b000, 1'b1, 1'b0, 3'b000, 3'b001, 16'd7);
        row(3'b000, 1'b1, 1'b0, 3'b000, 3'b001, 16'd7);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b001, 16'd7);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd7);
        // flush discards outstanding FU1/FU2 reservations
        row(3'b110, 1'b0, 1'b0, 3'b010, 3'b000, 16'd7);
        row(3'b110, 1'b0, 1'b0, 3'b100, 3'b000, 16'd8);
        row(3'b110, 1'b0, 1'b1, 3'b000, 3'b000, 16'd9);
        for (int c = 0; c < 5; c++) row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd9);
        // flush wins over stall
        row(3'b001, 1'b0, 1'b0, 3'b001, 3'b000, 16'd9);
        row(3'b000, 1'b1, 1'b1, 3'b000, 3'b001, 16'd9);
        row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd9);
        // reset mid-operation with a pending reservation
        row(3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 16'd9);
        #1;
        rst = 1'b0;
        #1;
        chk_val("midrst_gnt",   {13'd0, iss_gnt},   16'd0);
        chk_val("midrst_sel",   {13'd0, fu_sel},    16'd0);
        chk_val("midrst_valid", {15'd0, cdb_valid}, 16'd0);
        chk_val("midrst_deny",  deny_cnt,           16'd0);
        @(posedge clk);
        #3;
        rst     = 1'b1;
        iss_req = 3'b000;
        for (int c = 0; c < 5; c++) row(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
